// File: rtl/alu_sched_pkg.sv
// alu_sched shared types: FSM state encoding, ALU control codes, op tag.
// Optional op checking is enabled by defining ALU_SCHED_OPCHK_EN.
package alu_sched_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t ISSUE = 2'd1;
  localparam state_t RESP  = 2'd2;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  typedef struct packed {
    logic       id;
    logic [3:0] op;
  } tag_t;

  function automatic logic op_legal(
    input logic [3:0] op
  );
    case (op)
      OP_AND, OP_OR, OP_ADD,
      OP_SUB, OP_SLT: op_legal = 1'b1;
      default:        op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_sched_rr_arb2.sv
// Two-way round-robin arbiter.
// On contention the requester that did not win last time is granted.
import alu_sched_pkg::*;

module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // one-hot grant; last names the previous winner
  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b11): gnt = last ? 2'b01 : 2'b10;
      (req == 2'b01): gnt = 2'b01;
      (req == 2'b10): gnt = 2'b10;
      default:        gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_sched.sv
// alu_sched: two requesters sharing one external ALU, one op in flight.
// ALU_SCHED_OPCHK_EN: illegal ops bypass the ALU and return rsp_err.
import alu_sched_pkg::*;

module alu_sched #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [3:0]    req0_op,
  input  logic [3:0]    req1_op,
  output logic [1:0]    rsp_valid,
  input  logic [1:0]    rsp_ready,
  output logic [DW-1:0] rsp_result,
  output logic          rsp_zero,
  output logic          rsp_err,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_ctl,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_zero,
  output logic          busy
);

  state_t        state;
  logic          last_grant;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  tag_t          tag_q;
  logic [1:0]    gnt;
  logic          issue_ok;
  logic          in_issue;
  logic          rsp_fire;

  rr_arb2 u_arb (
    .req  (req_valid),
    .last (last_grant),
    .gnt  (gnt)
  );

`ifdef ALU_SCHED_OPCHK_EN
  assign issue_ok = op_legal(tag_q.op);
`else
  assign issue_ok = 1'b1;
`endif

  assign in_issue  = (state == ISSUE);
  assign rsp_fire  = (state == RESP) && rsp_ready[tag_q.id];
  assign busy      = (state != IDLE);

  // grant only while idle and out of reset
  assign req_ready = (rst_n && state == IDLE) ? gnt : 2'b00;

  assign alu_a   = (in_issue && issue_ok) ? a_q : '0;
  assign alu_b   = (in_issue && issue_ok) ? b_q : '0;
  assign alu_ctl = (in_issue && issue_ok) ? tag_q.op : 4'b0000;

  assign rsp_valid = (state != RESP) ? 2'b00 :
                     (tag_q.id ? 2'b10 : 2'b01);

  // FSM, arbitration history and operand capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      tag_q      <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (|gnt) begin
            state      <= ISSUE;
            last_grant <= gnt[1];
            a_q        <= gnt[1] ? req1_a : req0_a;
            b_q        <= gnt[1] ? req1_b : req0_b;
            tag_q.id   <= gnt[1];
            tag_q.op   <= gnt[1] ? req1_op : req0_op;
          end
        end
        (state == ISSUE): state <= RESP;
        (state == RESP): begin
          if (rsp_fire)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // response payload captured once, in ISSUE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else if (in_issue) begin
      rsp_result <= issue_ok ? alu_result : '0;
      rsp_zero   <= issue_ok ? alu_zero : 1'b0;
    end
  end

`ifdef ALU_SCHED_OPCHK_EN
  logic err_q;

  // flag ops that were not sent to the ALU
  always_ff @(posedge clk) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (in_issue)
      err_q <= !issue_ok;
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: vector table, contention,
// back-pressure, reset in flight and illegal-op sequences.
module tb_alu_sched;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_err;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        busy;

  alu_sched #(.DW(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req0_op    (req0_op),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctl    (alu_ctl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external shared ALU
  always_comb begin
    alu_result = 32'h0;
    case (alu_ctl)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0111: alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      default: alu_result = 32'h0;
    endcase
    alu_zero = (alu_result == 32'h0);
  end

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] res;
    logic        zero;
    int          hold;
  } vec_t;

  typedef struct packed {
    logic        id;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } exp_t;

  vec_t vecs[9];
  exp_t sbq[$];
  int   checks;
  int   errors;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // wait for the falling edge and score any response handshake
  task automatic neg();
    exp_t e;
    @(negedge clk);
    chk("rsp_onehot", {63'b0, $onehot0(rsp_valid)}, 64'd1);
    if (|(rsp_valid & rsp_ready)) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got rsp_valid %b expected none",
                 rsp_valid);
      end else begin
        e = sbq.pop_front();
        chk("rsp_id", rsp_valid, e.id ? 2'b10 : 2'b01);
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_zero", rsp_zero, e.zero);
        chk("rsp_err", rsp_err, e.err);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_ready"}, req_ready, 2'b00);
    chk({nm, "_rspv"}, rsp_valid, 2'b00);
    chk({nm, "_res"}, rsp_result, 32'h0);
    chk({nm, "_zero"}, rsp_zero, 1'b0);
    chk({nm, "_err"}, rsp_err, 1'b0);
    chk({nm, "_alua"}, alu_a, 32'h0);
    chk({nm, "_alub"}, alu_b, 32'h0);
    chk({nm, "_ctl"}, alu_ctl, 4'h0);
    chk({nm, "_busy"}, busy, 1'b0);
  endtask

  // one op from idle; entry and exit at posedge+1 with DUT idle
  task automatic run_op(input int id,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [3:0] op,
                        input logic [31:0] er,
                        input logic ez,
                        input logic ee,
                        input int hold);
    logic [1:0] me;
    me = (id == 1) ? 2'b10 : 2'b01;
    if (id == 1) begin
      req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_a = a; req0_b = b; req0_op = op;
    end
    req_valid = me;
    sbq.push_back('{id: (id == 1), res: er, zero: ez, err: ee});
    neg();
    chk("acc_ready", req_ready, me);
    chk("acc_busy", busy, 1'b0);
    chk("acc_ctl", alu_ctl, 4'h0);
    step();
    req_valid = 2'b00;
    neg();
    chk("iss_busy", busy, 1'b1);
    chk("iss_ready", req_ready, 2'b00);
    chk("iss_rspv", rsp_valid, 2'b00);
    chk("iss_ctl", alu_ctl, ee ? 4'h0 : op);
    if (!ee) begin
      chk("iss_alua", alu_a, a);
      chk("iss_alub", alu_b, b);
    end
    step();
    req_valid = 2'b11;
    rsp_ready = ~me;
    for (int i = 0; i < hold; i++) begin
      neg();
      chk("hold_rspv", rsp_valid, me);
      chk("hold_res", rsp_result, er);
      chk("hold_zero", rsp_zero, ez);
      chk("hold_err", rsp_err, ee);
      chk("hold_ready", req_ready, 2'b00);
      chk("hold_ctl", alu_ctl, 4'h0);
      step();
    end
    rsp_ready = me;
    neg();
    chk("resp_rspv", rsp_valid, me);
    chk("resp_ready", req_ready, 2'b00);
    step();
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    neg();
    chk("done_busy", busy, 1'b0);
    chk("done_rspv", rsp_valid, 2'b00);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] x_res;
    logic        x_zero;
    logic        x_err;
    int          g;

    checks = 0;
    errors = 0;
    vecs[0] = '{0, 32'd5, 32'd7, 4'b0010, 32'd12, 1'b0, 0};
    vecs[1] = '{1, 32'hf0f0f0f0, 32'hff00ff00, 4'b0000,
                32'hf000f000, 1'b0, 0};
    vecs[2] = '{0, 32'h0, 32'h0, 4'b0001, 32'h0, 1'b1, 5};
    vecs[3] = '{1, 32'd9, 32'd9, 4'b0110, 32'h0, 1'b1, 1};
    vecs[4] = '{0, 32'd3, 32'd5, 4'b0110, 32'hfffffffe, 1'b0, 0};
    vecs[5] = '{1, 32'd3, 32'd4, 4'b0111, 32'd1, 1'b0, 0};
    vecs[6] = '{0, 32'hffffffff, 32'd1, 4'b0111, 32'd1, 1'b0, 2};
    vecs[7] = '{1, 32'hffffffff, 32'd1, 4'b0010, 32'h0, 1'b1, 0};
    vecs[8] = '{0, 32'd4, 32'd3, 4'b0111, 32'h0, 1'b1, 0};

    rst_n = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    req0_a = 32'd9; req0_b = 32'd9; req0_op = 4'b0110;
    req1_a = 32'd3; req1_b = 32'd4; req1_op = 4'b0111;
    step();
    step();
    neg();
    chk_quiet("rst");
    step();
    req_valid = 2'b00;
    rst_n = 1'b1;

    // contention: both held, alternate 0,1,0 every 3 cycles
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int k = 0; k < 3; k++) begin
      g = k % 2;
      if (g == 0)
        sbq.push_back('{id: 1'b0, res: 32'h0, zero: 1'b1, err: 1'b0});
      else
        sbq.push_back('{id: 1'b1, res: 32'd1, zero: 1'b0, err: 1'b0});
      neg();
      chk("rr_ready", req_ready, (g == 1) ? 2'b10 : 2'b01);
      step();
      if (k == 2)
        req_valid = 2'b00;
      neg();
      chk("rr_iss_ready", req_ready, 2'b00);
      chk("rr_iss_busy", busy, 1'b1);
      step();
      neg();
      chk("rr_rspv", rsp_valid, (g == 1) ? 2'b10 : 2'b01);
      chk("rr_resp_ready", req_ready, 2'b00);
      step();
    end
    rsp_ready = 2'b00;
    neg();
    chk("rr_idle", busy, 1'b0);
    step();

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op,
             vecs[i].res, vecs[i].zero, 1'b0, vecs[i].hold);

`ifdef ALU_SCHED_OPCHK_EN
    x_res = 32'h0; x_zero = 1'b0; x_err = 1'b1;
`else
    x_res = 32'h0; x_zero = 1'b1; x_err = 1'b0;
`endif
    run_op(0, 32'h1234, 32'h5678, 4'b1111, x_res, x_zero, x_err, 0);
    run_op(1, 32'h1, 32'h2, 4'b1010, x_res, x_zero, x_err, 1);

    // reset during ISSUE discards the op
    req0_a = 32'd1; req0_b = 32'd2; req0_op = 4'b0010;
    req_valid = 2'b01;
    neg();
    chk("rsti_acc", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    rst_n = 1'b0;
    neg();
    chk("rsti_busy", busy, 1'b1);
    chk("rsti_ready", req_ready, 2'b00);
    step();
    neg();
    chk_quiet("rsti");
    step();
    rst_n = 1'b1;
    rsp_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      neg();
      chk("rsti_norsp", rsp_valid, 2'b00);
      chk("rsti_idle", busy, 1'b0);
      step();
    end
    rsp_ready = 2'b00;

    run_op(0, 32'd5, 32'd7, 4'b0010, 32'd12, 1'b0, 1'b0, 0);

    chk("sb_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 SHALL have parameter DW, default 32, operand/result width.
REQ-002 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have req_valid  input  2  per-requester operation request (bit i = requester i).
REQ-005 SHALL have req_ready  output  2  per-requester accept; request i is accepted when req_valid[i] & req_ready[i].
REQ-006 SHALL have req0_a, req0_b, req1_a, req1_b  input  DW each  operands for requesters 0 and 1.
REQ-007 SHALL have req0_op, req1_op  input  4 each  ALU control code (0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT).
REQ-008 SHALL have rsp_valid  output  2  one-hot response-valid, naming the requester that owns the response.
REQ-009 SHALL have rsp_ready  input  2  per-requester response accept.
REQ-010 SHALL have rsp_result  output  DW, rsp_zero  output  1, and rsp_err  output  1  response payload.
REQ-011 SHALL have alu_a, alu_b  output  DW and alu_ctl  output  4  drive to the shared external ALU.
REQ-012 SHALL have alu_result  input  DW and alu_zero  input  1  combinational return from the shared ALU.
REQ-013 SHALL have busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement the FSM IDLE -> ISSUE -> RESP -> IDLE with one operation in flight.
REQ-015 IDLE: if any req_valid is set, SHALL grant exactly one requester, assert its req_ready for that cycle only, latch its a/b/op and id, and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: with both valid, grant the requester that is not last_grant; with one valid, grant it regardless of last_grant.
REQ-017 last_grant SHALL update only when a request is accepted.
REQ-018 req_ready SHALL be 0 in ISSUE and RESP, and 0 in IDLE for the non-granted requester.
REQ-019 ISSUE: SHALL drive alu_a/alu_b/alu_ctl from the latched operands, register alu_result/alu_zero into the response register, and go to RESP.
REQ-020 Outside ISSUE, alu_a, alu_b and alu_ctl SHALL be 0.
REQ-021 RESP: SHALL assert rsp_valid[id] with a stable payload until rsp_ready[id] is high, then go to IDLE; rsp_ready of the other requester SHALL be ignored.
REQ-022 Latency SHALL be acceptance in cycle N, then rsp_valid in cycle N+2; peak throughput SHALL be one operation per 3 cycles.
REQ-023 A new request SHALL NOT be accepted in the cycle the response handshake completes.
REQ-024 rsp_zero SHALL equal alu_zero as sampled in ISSUE; the block SHALL NOT recompute it.

Reset
REQ-025 While rst_n=0 at a clock edge: state=IDLE, last_grant=1 (requester 0 wins the first contention), and req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, alu_a, alu_b, alu_ctl and busy SHALL all be 0.
REQ-026 A reset in ISSUE or RESP SHALL discard the in-flight operation with no response.

Configuration
REQ-027 Macro ALU_SCHED_OPCHK_EN defined: an accepted op outside {0000,0001,0010,0110,0111} SHALL bypass the ALU and go from ISSUE to RESP with rsp_result=0, rsp_zero=0 and rsp_err=1. alu_ctl SHALL stay 0 in that ISSUE cycle, and latency SHALL be unchanged.
REQ-028 Macro undefined: rsp_err SHALL be tied to 0, and every op SHALL be issued to the ALU unchanged.

Structure
REQ-029 Shared package alu_sched_pkg SHALL hold the FSM state typedef (IDLE, ISSUE, RESP) and the five ALU control-code constants.
REQ-030 Round-robin selection SHALL live in sub-module rr_arb2 (inputs req[1:0] and last; output one-hot gnt[1:0]).

Verification
REQ-031 Requester 0 only, ADD a=5 b=7, external ALU model -> req_ready[0] in cycle N, then rsp_valid=01 at N+2 with result=12, zero=0.
REQ-032 Both requesters valid and held, req0 SUB 9-9, req1 SLT 3<4 -> req0 served first with result=0, zero=1; then req1 with result=1; then req0 again.
REQ-033 Hold rsp_ready=00 for 5 cycles in RESP -> rsp_valid and payload stable and req_ready=00 throughout; accept on the 6th cycle, and no new accept in that cycle.
REQ-034 rst_n=0 in the ISSUE cycle -> next cycle all outputs 0, state IDLE, and no response emitted.
REQ-035 With ALU_SCHED_OPCHK_EN, op=1111 -> rsp_err=1 and result=0 at N+2, with alu_ctl=0 throughout; without the macro -> alu_ctl=1111 in ISSUE and rsp_err=0.
